// File: rtl/ccff_cfg_pkg.sv
// Shared definitions for the configuration-chain loader: FSM states,
// per-switch-block chain lengths and a sizing helper.
package ccff_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ccff_state_e;

    // sb_1__3_: 4x3 + 2x3 + 2x2 + 7x2 configuration bits
    localparam int SB_1__3_CHAIN_LEN = 36;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Single-word buffer that feeds one bit per cycle, LSB first, and refills in the
// same cycle its last bit leaves so a continuous stream has no bubbles.
module ccff_word_serializer
    import ccff_cfg_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              active,
    input  logic              pass_last,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              cur_bit,
    output logic              shift
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    logic [WORD_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              full_q, full_d;
    logic              word_last;
    logic              drain;

    always_comb begin
        shift     = active & full_q;
        word_last = shift & (idx_q == LAST_IDX);
        // The last bit of a pass drops any unused upper bits of a partial word.
        drain     = word_last | (shift & pass_last);
        bs_ready  = active & (~full_q | (word_last & ~pass_last));
        cur_bit   = word_q[idx_q];

        word_d = word_q;
        idx_d  = idx_q;
        full_d = full_q;
        if (flush) begin
            full_d = 1'b0;
            idx_d  = '0;
        end else if (bs_valid & bs_ready) begin
            word_d = bs_data;
            idx_d  = '0;
            full_d = 1'b1;
        end else if (drain) begin
            full_d = 1'b0;
            idx_d  = '0;
        end else if (shift) begin
            idx_d = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
            idx_q  <= '0;
            full_q <= 1'b0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
            full_q <= full_d;
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serialises a bitstream onto the chain head with a
// registered shift enable, optionally re-shifting it to verify the chain tail.
module ccff_chain_loader
    import ccff_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = SB_1__3_CHAIN_LEN,
    parameter int WORD_W    = 8,
    parameter int ERR_W     = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              verify_en,
    input  logic              abort,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              pass_ok,
    output logic [ERR_W-1:0]  err_count
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

    ccff_state_e      state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             pass_q, pass_d;
    logic             verify_q, verify_d;
    logic             head_q, head_d;
    logic             shift_en_q, shift_en_d;
    logic             cmp_q, cmp_d;
    logic             final_q, final_d;
    logic             done_q, done_d;
    logic             pass_ok_q, pass_ok_d;
    logic [ERR_W-1:0] err_q, err_d;

    logic active, pass_last, shift, cur_bit, accept_start;

    ccff_word_serializer #(.WORD_W(WORD_W)) u_ser (
        .clk      (prog_clk),
        .reset    (prog_reset),
        .flush    (abort),
        .active   (active),
        .pass_last(pass_last),
        .bs_data  (bs_data),
        .bs_valid (bs_valid),
        .bs_ready (bs_ready),
        .cur_bit  (cur_bit),
        .shift    (shift)
    );

    always_comb begin
        active       = (state_q == SHIFT);
        pass_last    = (bit_cnt_q == LAST_BIT);
        accept_start = start & ~abort & ((state_q == IDLE) | (state_q == DONE));

        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        pass_d     = pass_q;
        verify_d   = verify_q;
        head_d     = shift ? cur_bit : head_q;
        shift_en_d = shift;
        cmp_d      = shift & pass_q;
        final_d    = 1'b0;
        done_d     = final_q;
        pass_ok_d  = pass_ok_q;
        err_d      = err_q;

        // The bit on the outputs now is compared against the pre-shift tail.
        if (cmp_q && (ccff_tail != head_q) && (err_q != '1))
            err_d = err_q + ERR_W'(1);
        if (final_q)
            pass_ok_d = verify_q ? (err_d == '0) : 1'b1;

        if (abort) begin
            state_d    = IDLE;
            bit_cnt_d  = '0;
            pass_d     = 1'b0;
            shift_en_d = 1'b0;
            cmp_d      = 1'b0;
            done_d     = 1'b0;
            pass_ok_d  = 1'b0;
        end else if (accept_start) begin
            state_d   = SHIFT;
            bit_cnt_d = '0;
            pass_d    = 1'b0;
            verify_d  = verify_en;
            err_d     = '0;
            pass_ok_d = 1'b0;
        end else if (shift) begin
            if (pass_last) begin
                bit_cnt_d = '0;
                if (!pass_q && verify_q) begin
                    pass_d = 1'b1;
                end else begin
                    pass_d  = 1'b0;
                    state_d = DONE;
                    final_d = 1'b1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            pass_q     <= 1'b0;
            verify_q   <= 1'b0;
            head_q     <= 1'b0;
            shift_en_q <= 1'b0;
            cmp_q      <= 1'b0;
            final_q    <= 1'b0;
            done_q     <= 1'b0;
            pass_ok_q  <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            pass_q     <= pass_d;
            verify_q   <= verify_d;
            head_q     <= head_d;
            shift_en_q <= shift_en_d;
            cmp_q      <= cmp_d;
            final_q    <= final_d;
            done_q     <= done_d;
            pass_ok_q  <= pass_ok_d;
            err_q      <= err_d;
        end
    end

    assign busy          = active;
    assign ccff_head     = head_q;
    assign ccff_shift_en = shift_en_q;
    assign done          = done_q;
    assign pass_ok       = pass_ok_q;
    assign err_count     = err_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a shift-register model of the chain, directed
// scenarios and randomized loads compared against stream arithmetic.
module tb_ccff_chain_loader;
    import ccff_cfg_pkg::*;

    localparam int L  = SB_1__3_CHAIN_LEN;
    localparam int W  = 8;
    localparam int NW = ceil_div(L, W);

    logic         prog_clk = 1'b0;
    logic         prog_reset, start, verify_en, abort, bs_valid;
    logic [W-1:0] bs_data;
    logic         bs_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done, pass_ok;
    logic [7:0]   err_count;
    logic         bs_ready2, head2, shift_en2, busy2, done2, pass_ok2;
    logic [1:0]   err2;

    ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(W), .ERR_W(8)) dut (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start), .verify_en(verify_en),
        .abort(abort), .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(bs_ready),
        .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
        .busy(busy), .done(done), .pass_ok(pass_ok), .err_count(err_count)
    );

    // Narrow counter copy sharing every input, used to see saturation.
    ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(W), .ERR_W(2)) dut2 (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start), .verify_en(verify_en),
        .abort(abort), .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(bs_ready2),
        .ccff_head(head2), .ccff_shift_en(shift_en2), .ccff_tail(ccff_tail),
        .busy(busy2), .done(done2), .pass_ok(pass_ok2), .err_count(err2)
    );

    always #5 prog_clk = ~prog_clk;

    // Chain model: chain[0] is the head flop, chain[L-1] drives the tail.
    logic [L-1:0] chain = '0;
    logic [L-1:0] inject_mask = '0;
    int           inject_req = 0;
    int           inject_ack = 0;
    assign ccff_tail = chain[L-1];

    always @(posedge prog_clk) begin : chain_model
        logic [L-1:0] nxt;
        nxt = chain;
        if (ccff_shift_en) nxt = {chain[L-2:0], ccff_head};
        if (inject_req != inject_ack) begin
            nxt = nxt ^ inject_mask;
            inject_ack <= inject_req;
        end
        chain <= nxt;
    end

    int total = 0;
    int bad = 0;

    logic [W-1:0] words [NW];
    bit           run_verify;
    int           abort_at, reset_at, startmid_at, stall_word, stall_left, stall_pct;
    logic [L-1:0] flip_mask;

    int         shifts, shifts2, gaps, stalls, dones, dones2, seq_bad, seq2_bad;
    bit         timed_out;
    logic [7:0] first8;
    logic       ev_shift_en, ev_busy, ev_ready, ev_done, ev_pass_ok, ev_head;
    logic       ev2_shift_en, ev2_busy, ev2_ready, ev2_done, ev2_pass_ok, ev2_head;
    logic [7:0] ev_err;
    logic [1:0] ev2_err;

    function automatic logic stream_bit(input int k);
        logic [W-1:0] w;
        w = words[k / W];
        return w[k % W];
    endfunction

    // After a full pass the bit shifted k-th sits k flops back from the tail.
    function automatic logic [L-1:0] expected_chain();
        logic [L-1:0] v;
        for (int k = 0; k < L; k++) v[L-1-k] = stream_bit(k);
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setRun(input bit v);
        run_verify  = v;
        abort_at    = -1;
        reset_at    = -1;
        startmid_at = -1;
        stall_word  = -1;
        stall_left  = 0;
        stall_pct   = 0;
        flip_mask   = '0;
    endtask

    task automatic randomWords();
        for (int i = 0; i < NW; i++) words[i] = W'($urandom);
    endtask

    // Runs one load from start until done (plus two cycles) or until the cycle
    // after an abort/reset event, sampling every output on the falling edge.
    task automatic applyStimulus();
        logic [W-1:0] wq[$];
        int  n, accepted, cyc, post;
        bit  ended, evt, injected, mid_done;
        wq.delete();
        for (int p = 0; p < (run_verify ? 2 : 1); p++)
            for (int i = 0; i < NW; i++) wq.push_back(words[i]);
        n = run_verify ? 2 * L : L;
        {shifts, shifts2, gaps, stalls, dones, dones2, seq_bad, seq2_bad} = '0;
        first8 = '0;
        accepted = 0; cyc = 0; post = 0;
        ended = 0; evt = 0; injected = 0; mid_done = 0;
        @(negedge prog_clk);
        start = 1'b1;
        verify_en = run_verify;
        while (!ended && cyc < 800) begin
            @(negedge prog_clk);
            cyc++;
            start = 1'b0; abort = 1'b0; prog_reset = 1'b0;
            if (ccff_shift_en) begin
                if (shifts < 8) first8[shifts] = ccff_head;
                if (ccff_head !== stream_bit(shifts % L)) seq_bad++;
                shifts++;
            end else if (shifts > 0 && shifts < n) begin
                gaps++;
            end
            if (shift_en2) begin
                if (head2 !== stream_bit(shifts2 % L)) seq2_bad++;
                shifts2++;
            end
            if (done) dones++;
            if (done2) dones2++;
            if (evt) begin
                {ev_shift_en, ev_busy, ev_ready, ev_done, ev_pass_ok, ev_head, ev_err} =
                    {ccff_shift_en, busy, bs_ready, done, pass_ok, ccff_head, err_count};
                {ev2_shift_en, ev2_busy, ev2_ready, ev2_done, ev2_pass_ok, ev2_head, ev2_err} =
                    {shift_en2, busy2, bs_ready2, done2, pass_ok2, head2, err2};
                ended = 1;
            end else begin
                if (dones > 0) begin
                    post++;
                    if (post >= 3) ended = 1;
                end
                if (run_verify && !injected && shifts == L && flip_mask != '0) begin
                    inject_mask = flip_mask;
                    inject_req++;
                    injected = 1;
                end
                if (shifts == abort_at) begin
                    abort = 1'b1;
                    start = 1'b1;
                    evt = 1;
                end else if (shifts == reset_at) begin
                    prog_reset = 1'b1;
                    evt = 1;
                end else if (shifts == startmid_at && !mid_done) begin
                    start = 1'b1;
                    verify_en = ~run_verify;
                    mid_done = 1;
                end
                if (!evt && wq.size() > 0) begin
                    if (bs_ready && ((accepted == stall_word && stall_left > 0) ||
                                     int'($urandom_range(99)) < stall_pct)) begin
                        bs_valid = 1'b0;
                        if (accepted == stall_word && stall_left > 0) stall_left--;
                        if (accepted > 0) stalls++;
                    end else begin
                        bs_valid = 1'b1;
                        bs_data  = wq[0];
                        if (bs_ready) begin
                            void'(wq.pop_front());
                            accepted++;
                        end
                    end
                end else begin
                    bs_valid = 1'b0;
                end
            end
        end
        bs_valid = 1'b0;
        timed_out = !ended;
    endtask

    task automatic checkRun(input string tag, input int exp_gaps);
        int nflip;
        nflip = run_verify ? $countones(flip_mask) : 0;
        checkOutput({tag, ":finished"},  64'(timed_out), 64'(0));
        checkOutput({tag, ":shifts"},    64'(shifts), 64'(run_verify ? 2 * L : L));
        checkOutput({tag, ":head_seq"},  64'(seq_bad), 64'(0));
        checkOutput({tag, ":done_cnt"},  64'(dones), 64'(1));
        checkOutput({tag, ":chain"},     64'(chain), 64'(expected_chain()));
        checkOutput({tag, ":err_count"}, 64'(err_count), 64'(nflip));
        checkOutput({tag, ":pass_ok"},   64'(pass_ok), 64'(nflip == 0));
        checkOutput({tag, ":gaps"},      64'(gaps), 64'(exp_gaps));
        checkOutput({tag, ":sat_err"},   64'(err2), 64'(nflip > 3 ? 3 : nflip));
        checkOutput({tag, ":sat_seq"},   64'(seq2_bad + shifts2 + dones2), 64'(shifts + 1));
    endtask

    initial begin
        prog_reset = 1'b1; start = 1'b0; verify_en = 1'b0; abort = 1'b0;
        bs_valid = 1'b0; bs_data = '0;
        repeat (3) @(negedge prog_clk);
        checkOutput("rst:outs", 64'({bs_ready, ccff_head, ccff_shift_en, busy, done, pass_ok}), 64'(0));
        checkOutput("rst:err", 64'(err_count), 64'(0));
        checkOutput("rst:outs2", 64'({bs_ready2, head2, shift_en2, busy2, done2, pass_ok2, err2}), 64'(0));
        prog_reset = 1'b0;

        $display("[TB] plain load");
        setRun(0);
        words = '{8'hA5, 8'h3C, 8'hF0, 8'h0F, 8'h09};
        applyStimulus();
        checkRun("load", 0);
        checkOutput("load:first8", 64'(first8), 64'(8'hA5));

        $display("[TB] verify with discarded upper nibble");
        setRun(1);
        words[4] = 8'hF9;
        applyStimulus();
        checkRun("verify", 1);

        $display("[TB] verify with corrupted chain bit 10");
        setRun(1);
        flip_mask[L-1-10] = 1'b1;
        applyStimulus();
        checkRun("flip10", 1);

        $display("[TB] three-cycle stall before word 3");
        setRun(0);
        words[4] = 8'h09;
        stall_word = 2;
        stall_left = 3;
        applyStimulus();
        checkRun("stall", 3);

        $display("[TB] abort with simultaneous start at bit 17");
        setRun(0);
        abort_at = 17;
        applyStimulus();
        checkOutput("abort:outs", 64'({ev_shift_en, ev_busy, ev_ready, ev_done, ev_pass_ok}), 64'(0));
        checkOutput("abort:err", 64'(ev_err), 64'(0));

        setRun(0);
        randomWords();
        startmid_at = 10;
        applyStimulus();
        checkRun("reload", 0);

        $display("[TB] abort in verify pass keeps error count");
        setRun(1);
        randomWords();
        flip_mask[L-1-3] = 1'b1;
        abort_at = L + 20;
        applyStimulus();
        checkOutput("abortv:outs", 64'({ev_shift_en, ev_busy, ev_ready, ev_done, ev_pass_ok}), 64'(0));
        checkOutput("abortv:err", 64'(ev_err), 64'(1));

        $display("[TB] reset at bit 20 of verify pass");
        setRun(1);
        randomWords();
        flip_mask[L-1-3] = 1'b1;
        flip_mask[L-1-7] = 1'b1;
        reset_at = L + 20;
        applyStimulus();
        checkOutput("reset:outs", 64'({ev_ready, ev_head, ev_shift_en, ev_busy, ev_done, ev_pass_ok, ev_err}), 64'(0));
        checkOutput("reset:outs2", 64'({ev2_ready, ev2_head, ev2_shift_en, ev2_busy, ev2_done, ev2_pass_ok, ev2_err}), 64'(0));

        $display("[TB] five mismatches against narrow counter");
        setRun(1);
        randomWords();
        for (int i = 0; i < 5; i++) flip_mask[L-1-(2 + 7 * i)] = 1'b1;
        applyStimulus();
        checkRun("sat", 1);
        checkOutput("sat:pass_ok2", 64'(pass_ok2), 64'(0));

        $display("[TB] randomized loads");
        for (int r = 0; r < 6; r++) begin
            setRun(1'($urandom_range(1)));
            randomWords();
            stall_pct = 25;
            repeat ($urandom_range(4)) flip_mask[$urandom_range(L - 1)] = 1'b1;
            applyStimulus();
            checkRun($sformatf("rand%0d", r), stalls + (run_verify ? 1 : 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
